// File: rtl/serializer_arbiter.sv
// serializer_arbiter: round-robin arbiter that grants one requester at a time a
// framed serial line and serializes the granted word itself.
// Frame: start bit (0), WIDTH data bits LSB first, optional even parity bit, stop bit (1).
// Each bit is held for CLKS_PER_BIT clocks.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - synchronous active-low reset
//   req      - per-requester request, held until granted
//   data     - packed requester words; requester i on [i*WIDTH +: WIDTH]
//   grant    - one-hot, one-cycle pulse marking the accepted word
//   ser_out  - serial line, idles high
//   busy     - high while a frame is on the line
//   done     - one-cycle pulse in the idle cycle after a stop bit
module serializer_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned PARITY       = 1,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         grant,
    output logic                    ser_out,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [DW-1:0]      div_q, div_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               par_q, par_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic               ser_q, ser_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               found;
    logic [PW-1:0]      win;
    logic [WIDTH-1:0]   win_word;
    logic [WIDTH-1:0]   shreg_next;
    logic               bit_end;
    int                 idx;

    // Round-robin search: first set request at or above ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_word = '0;
        idx      = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
            if (!found && req[idx]) begin
                found    = 1'b1;
                win      = PW'(idx);
                win_word = data[idx*WIDTH +: WIDTH];
            end
        end
    end

    assign bit_end    = (div_q == DW'(CLKS_PER_BIT - 1));
    assign shreg_next = shreg_q >> 1;

    // ser_d is the value the line shows in the next cycle, so every output stays registered.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bit_d   = bit_q;
        div_d   = '0;
        shreg_d = shreg_q;
        par_d   = par_q;
        grant_d = '0;
        ser_d   = ser_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != StIdle) begin
            div_d = bit_end ? '0 : div_q + DW'(1);
        end

        unique case (state_q)
            StIdle: begin
                ser_d  = 1'b1;
                busy_d = 1'b0;
                if (found) begin
                    grant_d = NREQ'(1) << win;
                    shreg_d = win_word;
                    par_d   = ^win_word;
                    ptr_d   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                    ser_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    ser_d   = shreg_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == BW'(WIDTH - 1)) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = StPar;
                            ser_d   = par_q;
                        end else begin
                            state_d = StStop;
                            ser_d   = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BW'(1);
                        shreg_d = shreg_next;
                        ser_d   = shreg_next[0];
                    end
                end
            end
            StPar: begin
                if (bit_end) begin
                    state_d = StStop;
                    ser_d   = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ser_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            grant_q <= '0;
            ser_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            grant_q <= grant_d;
            ser_q   <= ser_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign grant   = grant_q;
    assign ser_out = ser_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Bench for serializer_arbiter: three instances (defaults; slow odd-parity; narrow no-parity)
// share clock and reset. Expected per-cycle outputs are queued per instance when a
// request is driven and popped one per clock; an empty queue means the line must idle.
module tb_serializer_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req_a, grant_a;
    logic [31:0] data_a;
    logic        ser_a, busy_a, done_a;
    logic [1:0]  req_b, grant_b;
    logic [15:0] data_b;
    logic        ser_b, busy_b, done_b;
    logic [1:0]  req_c, grant_c;
    logic [7:0]  data_c;
    logic        ser_c, busy_c, done_c;

    serializer_arbiter #(.NREQ(4), .WIDTH(8), .PARITY(1), .CLKS_PER_BIT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .data(data_a),
        .grant(grant_a), .ser_out(ser_a), .busy(busy_a), .done(done_a)
    );
    serializer_arbiter #(.NREQ(2), .WIDTH(8), .PARITY(1), .CLKS_PER_BIT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .data(data_b),
        .grant(grant_b), .ser_out(ser_b), .busy(busy_b), .done(done_b)
    );
    serializer_arbiter #(.NREQ(2), .WIDTH(4), .PARITY(0), .CLKS_PER_BIT(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .data(data_c),
        .grant(grant_c), .ser_out(ser_c), .busy(busy_c), .done(done_c)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic       ser;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input string name, input exp_t e, input logic [3:0] g,
                             input logic s, input logic b, input logic d);
        check({name, ".grant"}, g, e.grant);
        check({name, ".ser_out"}, {3'b0, s}, {3'b0, e.ser});
        check({name, ".busy"}, {3'b0, b}, {3'b0, e.busy});
        check({name, ".done"}, {3'b0, d}, {3'b0, e.done});
    endtask

    task automatic push(input int d, input logic [3:0] g, input logic s, input logic b,
                        input logic dn);
        exp_t e;
        e.grant = g;
        e.ser   = s;
        e.busy  = b;
        e.done  = dn;
        case (d)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    // Whole frame as seen from the first start-bit cycle through the done cycle.
    task automatic push_frame(input int d, input logic [3:0] g, input logic [7:0] w,
                              input int width, input int par, input int cpb);
        logic pb;
        pb = 1'b0;
        for (int i = 0; i < width; i++) pb = pb ^ w[i];
        for (int c = 0; c < cpb; c++) push(d, (c == 0) ? g : 4'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < width; i++)
            for (int c = 0; c < cpb; c++) push(d, 4'b0, w[i], 1'b1, 1'b0);
        if (par != 0)
            for (int c = 0; c < cpb; c++) push(d, 4'b0, pb, 1'b1, 1'b0);
        for (int c = 0; c < cpb; c++) push(d, 4'b0, 1'b1, 1'b1, 1'b0);
        push(d, 4'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic step();
        exp_t ea, eb, ec, idle;
        idle.grant = 4'b0;
        idle.ser   = 1'b1;
        idle.busy  = 1'b0;
        idle.done  = 1'b0;
        ea = idle;
        eb = idle;
        ec = idle;
        @(posedge clk);
        #1;
        if (qa.size() != 0) ea = qa.pop_front();
        if (qb.size() != 0) eb = qb.pop_front();
        if (qc.size() != 0) ec = qc.pop_front();
        check_dut("A", ea, grant_a, ser_a, busy_a, done_a);
        check_dut("B", eb, {2'b0, grant_b}, ser_b, busy_b, done_b);
        check_dut("C", ec, {2'b0, grant_c}, ser_c, busy_c, done_c);
    endtask

    // Each step pops an entry, so this is bounded by the queued frame lengths.
    task automatic drain();
        while (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        qc.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        req_a  = '0;
        req_b  = '0;
        req_c  = '0;
        data_a = {8'h3C, 8'h96, 8'h5A, 8'hA5};
        data_b = {8'h00, 8'h07};
        data_c = {4'h0, 4'hC};
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single request, default frame of A5: done lands in cycle 12.
        req_a = 4'b0001;
        push_frame(0, 4'b0001, 8'hA5, 8, 1, 1);
        step();
        req_a = 4'b0000;
        drain();

        // All requesting from reset: strict rotation, 12 cycles apart.
        do_reset();
        req_a = 4'b1111;
        push_frame(0, 4'b0001, 8'hA5, 8, 1, 1);
        push_frame(0, 4'b0010, 8'h5A, 8, 1, 1);
        push_frame(0, 4'b0100, 8'h96, 8, 1, 1);
        push_frame(0, 4'b1000, 8'h3C, 8, 1, 1);
        push_frame(0, 4'b0001, 8'hA5, 8, 1, 1);
        drain();
        req_a = 4'b0000;

        // Hole in the request pattern: pointer wraps and skips idle requesters.
        do_reset();
        req_a = 4'b1010;
        push_frame(0, 4'b0010, 8'h5A, 8, 1, 1);
        push_frame(0, 4'b1000, 8'h3C, 8, 1, 1);
        push_frame(0, 4'b0010, 8'h5A, 8, 1, 1);
        drain();
        req_a = 4'b0000;

        // Slow odd-parity frame and narrow no-parity frame in parallel.
        req_b = 2'b01;
        req_c = 2'b01;
        push_frame(1, 4'b0001, 8'h07, 8, 1, 3);
        push_frame(2, 4'b0001, 8'h0C, 4, 0, 1);
        step();
        req_b = 2'b00;
        req_c = 2'b00;
        drain();

        // Reset in the middle of the data bits: frame abandoned, pointer back to 0.
        req_a = 4'b0001;
        push_frame(0, 4'b0001, 8'hA5, 8, 1, 1);
        step();
        req_a = 4'b0000;
        repeat (4) step();
        do_reset();
        req_a = 4'b0011;
        push_frame(0, 4'b0001, 8'hA5, 8, 1, 1);
        push_frame(0, 4'b0010, 8'h5A, 8, 1, 1);
        step();
        req_a = 4'b0010;
        drain();
        req_a = 4'b0000;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
